edge_count_window_ctrl: RTL and testbench
=========================================

# edge_count_window_ctrl

Measurement-window controller wrapped around an 8-bit bit-transition counting datapath. On a `start` command it captures a baseline sample of `in_`, then accumulates the number of bit flips across all 8 lanes for a programmed number of cycles. It presents the total on a valid/ready output port and holds it until the result is consumed. It sits between the sampled 8-bit input and a downstream statistics consumer, which issues the windows.

## Interface
- `WIN_W`, default 8: width of the window-length field; legal range 1..16.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a new window; accepted only in IDLE.
- `abort`  in  1: cancel an in-progress window; honoured in PRIME and COUNT only.
- `cfg_win_len`  in  WIN_W: number of counting cycles; sampled on the cycle `start` is accepted.
- `in_`  in  8: sampled input word.
- `busy`  out  1: high in PRIME, COUNT and DONE.
- `out_val`  out  1: result valid; high exactly in DONE.
- `out_rdy`  in  1: consumer ready.
- `out_count`  out  16: transition total for the window; valid when `out_val`=1.

## Operation
- Registered state `{IDLE, PRIME, COUNT, DONE}`, plus the following registers:
  - `prev` (8 bits)
  - `remaining` (WIN_W bits)
  - `acc` (16 bits)
- IDLE:
  - `start`=1: latch `cfg_win_len` into `remaining`, clear `acc`, go to PRIME.
  - Otherwise remain in IDLE.
  - `abort` has no effect in IDLE. With `start`=1 and `abort`=1 together, `start` is taken.
- PRIME (exactly one cycle):
  - `prev` <= `in_`; no counting.
  - If `abort`, go to IDLE.
  - Else if `remaining`==0, go to DONE with `acc`=0.
  - Else go to COUNT.
- COUNT:
  - `acc` <= sat16(`acc` + popcount(`prev` ^ `in_`)).
  - `prev` <= `in_`.
  - `remaining` <= `remaining`-1.
  - When `remaining`==1, go to DONE after that cycle's update.
  - If `abort`, go to IDLE and discard this cycle's update; `acc` is not presented.
- DONE:
  - `out_val`=1, `out_count`=`acc`.
  - On `out_val`&&`out_rdy`, go to IDLE.
  - `start` and `abort` are ignored.
- Arithmetic: popcount is 0..8. The accumulator saturates at 0xFFFF and never wraps; once saturated, further edges leave it at 0xFFFF.
- `start` while `busy` is dropped, not queued.

## Timing
- Reset values:
  - state=IDLE
  - `busy`=0, `out_val`=0
  - `out_count`=0x0000
  - `prev`=0, `remaining`=0, `acc`=0
- Reset is asynchronous. Asserting it mid-window or in DONE discards all results with no output transfer. The first `start` is accepted on the first rising edge after deassertion.
- `start` accepted at edge T: PRIME during cycle T+1; COUNT during T+2 .. T+1+L, where L=`cfg_win_len`; DONE from T+2+L.
- With L=0, DONE is reached at T+2.
- Start-to-`out_val` latency is L+2 cycles. The minimum back-to-back window period is L+3 cycles when `out_rdy` is held high.
- `in_` is sampled on cycles T+1 .. T+1+L, which is L+1 samples producing L comparisons.
- `out_val` and `out_count` come straight from registers, with no combinational path from inputs. They are stable while `out_val`=1 and `out_rdy`=0.
- `abort` seen at edge E in PRIME/COUNT: IDLE from E+1, and `busy` falls in cycle E+1.

## Configuration
- `EDGE_WIN_ALARM_EN` defined:
  - Adds input `cfg_thresh` (16 bits), latched with `cfg_win_len` on `start` acceptance.
  - Adds output `out_alarm` (1 bit), registered: `out_alarm`=1 in DONE when `acc` > latched threshold, else 0.
  - `out_alarm` is 0 outside DONE and at reset.
  - A saturated `acc`=0xFFFF never alarms for threshold 0xFFFF.
- `EDGE_WIN_ALARM_EN` not defined: neither port exists, and the threshold register and comparator are absent. All other behaviour is identical.

## Test plan
- Reset low, `start`=1, `in_` toggling: `busy`=0, `out_val`=0, `out_count`=0 throughout. After release, a `start` is accepted on the first edge.
- L=4, `in_` sequence 0x00 (PRIME), 0xFF, 0x0F, 0x0F, 0xF0, with `out_rdy`=1:
  - `out_count`=8+4+0+8=20.
  - `out_val` is high for exactly one cycle, 6 cycles after the start edge; next `start` accepted the cycle after.
- L=0: `out_val` 2 cycles after `start` with `out_count`=0. With `out_rdy` low for 5 cycles, `out_val`/`out_count` hold steady and a `start` pulse during DONE is ignored.
- WIN_W=16, L=0xFFFF, `in_` alternating 0x00/0xFF:
  - `out_count` saturates at 0xFFFF without wrap.
  - With `EDGE_WIN_ALARM_EN` and `cfg_thresh`=0xFFFE: `out_alarm`=1.
  - With `cfg_thresh`=0xFFFF: `out_alarm`=0.
- L=10, `abort` in 3rd COUNT cycle: `busy` low next cycle, no `out_val`. A new window with L=2 then reports only its own edges.
- L=10, reset asserted asynchronously in COUNT mid-cycle: outputs go to reset values immediately. `start` with `abort` high in IDLE still launches a window.

Source files
------------

// File: rtl/edge_count_window_ctrl.sv
// rtl/edge_count_window_ctrl.sv - windowed 8-lane bit-transition counter with valid/ready result
// Optional threshold alarm enabled by defining EDGE_WIN_ALARM_EN.
module edge_count_window_ctrl #(
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] cfg_win_len,
  input  logic [7:0]       in_,
  output logic             busy,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [15:0]      out_count
`ifdef EDGE_WIN_ALARM_EN
  ,
  input  logic [15:0]      cfg_thresh,
  output logic             out_alarm
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [7:0]       r_prev;
  logic [WIN_W-1:0] r_remaining;
  logic [15:0]      r_acc;

  logic [1:0]       w_state_nxt;
  logic [7:0]       w_prev_nxt;
  logic [WIN_W-1:0] w_rem_nxt;
  logic [15:0]      w_acc_nxt;
  logic [7:0]       w_diff;
  logic [3:0]       w_pop;
  logic [16:0]      w_sum;
  logic [15:0]      w_sat;

  always_comb begin
    w_diff = r_prev ^ in_;
    w_pop  = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'b000, w_diff[i]};
    end
    w_sum = {1'b0, r_acc} + {13'd0, w_pop};
    // Clamp instead of wrapping so long busy windows still report a usable ceiling.
    w_sat = w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_rem_nxt   = r_remaining;
    w_acc_nxt   = r_acc;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rem_nxt   = cfg_win_len;
          w_acc_nxt   = 16'd0;
          w_state_nxt = S_PRIME;
        end
      end
      S_PRIME: begin
        w_prev_nxt = in_;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_remaining == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_acc_nxt  = w_sat;
          w_prev_nxt = in_;
          w_rem_nxt  = r_remaining - WIN_W'(1);
          if (r_remaining == WIN_W'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_rdy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_prev      <= 8'd0;
      r_remaining <= '0;
      r_acc       <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= w_prev_nxt;
      r_remaining <= w_rem_nxt;
      r_acc       <= w_acc_nxt;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign out_val   = (r_state == S_DONE);
  assign out_count = r_acc;

`ifdef EDGE_WIN_ALARM_EN
  logic [15:0] r_thresh;
  logic        r_alarm;

  // Alarm is precomputed from next-state values so it is a plain register in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_thresh <= 16'd0;
      r_alarm  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_thresh <= cfg_thresh;
      end
      r_alarm <= (w_state_nxt == S_DONE) && (w_acc_nxt > r_thresh);
    end
  end

  assign out_alarm = r_alarm;
`endif

endmodule

// File: tb/tb_edge_count_window_ctrl.sv
// tb/tb_edge_count_window_ctrl.sv - scoreboard bench for edge_count_window_ctrl
module tb_edge_count_window_ctrl;
  localparam int WIN_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             out_rdy = 1'b1;
  logic [WIN_W-1:0] cfg_win_len = '0;
  logic [7:0]       in_ = 8'd0;
  logic             busy;
  logic             out_val;
  logic [15:0]      out_count;
`ifdef EDGE_WIN_ALARM_EN
  logic [15:0]      cfg_thresh = 16'd0;
  logic             out_alarm;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_q[$];
  logic alarm_q[$];
  logic [7:0] smp[$];

  edge_count_window_ctrl #(.WIN_W(WIN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .cfg_win_len (cfg_win_len),
    .in_         (in_),
    .busy        (busy),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .out_count   (out_count)
`ifdef EDGE_WIN_ALARM_EN
    ,
    .cfg_thresh  (cfg_thresh),
    .out_alarm   (out_alarm)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model();
    int acc;
    acc = 0;
    for (int i = 1; i < smp.size(); i++) begin
      acc = acc + $countones(smp[i] ^ smp[i-1]);
      if (acc > 65535) acc = 65535;
    end
    return acc;
  endfunction

  task automatic fill_rand(input int n);
    smp.delete();
    for (int i = 0; i < n; i++) smp.push_back(8'($urandom));
  endtask

  task automatic fill_alt(input int n);
    smp.delete();
    for (int i = 0; i < n; i++) smp.push_back((i % 2 == 0) ? 8'h00 : 8'hFF);
  endtask

  // Transfer happens on the edge following this negedge; pop and compare there.
  always @(negedge clk) begin
    if (reset && out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_val", 1, 0);
      end else begin
        check("sb_out_count", {16'd0, out_count}, exp_q.pop_front());
`ifdef EDGE_WIN_ALARM_EN
        check("sb_out_alarm", {31'd0, out_alarm}, {31'd0, alarm_q.pop_front()});
`endif
      end
    end
  end

  // smp must hold len+1 samples; exp_fixed >= 0 adds a hand-derived count check.
  task automatic run_window(input int len, input logic [15:0] thr, input bit abt, input int exp_fixed);
    int e;
    e = model();
    exp_q.push_back(e);
    alarm_q.push_back(e > int'(thr));
    start = 1'b1;
    abort = abt;
    cfg_win_len = len[WIN_W-1:0];
`ifdef EDGE_WIN_ALARM_EN
    cfg_thresh = thr;
`endif
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("busy_after_start", busy, 1);
    for (int k = 0; k <= len; k++) begin
      in_ = smp[k];
      tick();
    end
    check("out_val_at_L_plus_2", out_val, 1);
    if (exp_fixed >= 0) check("fixed_count", {16'd0, out_count}, exp_fixed);
    if (out_rdy) begin
      tick();
      check("out_val_one_cycle", out_val, 0);
      check("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_ = 8'($urandom);
      tick();
      check("rst_busy", busy, 0);
      check("rst_out_val", out_val, 0);
      check("rst_out_count", {16'd0, out_count}, 0);
    end
    @(negedge clk);
    reset = 1'b1;

    // L=4 hand vector, first start right after reset release
    smp.delete();
    smp.push_back(8'h00); smp.push_back(8'hFF); smp.push_back(8'h0F);
    smp.push_back(8'h0F); smp.push_back(8'hF0);
    run_window(4, 16'd19, 1'b0, 20);

    // back-to-back random windows
    for (int w = 0; w < 4; w++) begin
      fill_rand(w + 2);
      run_window(w + 1, 16'd6, 1'b0, -1);
    end

    // L=0 with consumer stalled and a stray start during DONE
    out_rdy = 1'b0;
    smp.delete();
    smp.push_back(8'h5A);
    run_window(0, 16'd0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      check("hold_out_val", out_val, 1);
      check("hold_out_count", {16'd0, out_count}, 0);
    end
    start = 1'b0;
    out_rdy = 1'b1;
    tick();
    check("stray_start_ignored", busy, 0);

    // abort in the third COUNT cycle
    fill_rand(11);
    smp[0] = 8'h00; smp[1] = 8'hFF; smp[2] = 8'h00;
    start = 1'b1;
    cfg_win_len = 16'd10;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_ = smp[k];
      tick();
    end
    in_ = smp[3];
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_out_val", out_val, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_out_val", out_val, 0);
    end
    fill_rand(3);
    run_window(2, 16'd4, 1'b0, -1);

    // asynchronous reset in the middle of COUNT
    fill_alt(11);
    start = 1'b1;
    cfg_win_len = 16'd10;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_ = smp[k];
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_out_val", out_val, 0);
    check("async_rst_out_count", {16'd0, out_count}, 0);
    @(negedge clk);
    reset = 1'b1;

    // start together with abort in IDLE still launches
    fill_rand(2);
    run_window(1, 16'd3, 1'b1, -1);

    // saturation over a full-length window, then a shorter saturating one
    fill_alt(65536);
    run_window(65535, 16'hFFFE, 1'b0, 65535);
    fill_alt(8449);
    run_window(8448, 16'hFFFF, 1'b0, 65535);

    for (int i = 0; i < 3; i++) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
